// File: rtl/div_iter_pkg.sv
// Shared state codes, handshake constants and two's-complement helpers
// for the iterative divider.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic       DivResultReady    = 1'b1;
  localparam logic       DivResultNotReady = 1'b0;
  localparam logic       DivStart          = 1'b1;
  localparam logic       DivStop           = 1'b0;
  localparam logic [5:0] DivIterCnt        = 6'd32;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return neg32(v);
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_iter_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient}, held while EX keeps start high.
module div_iter
  import div_iter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  div_state_e  state_r;
  logic [5:0]  cnt_r;
  logic [64:0] dividend_r;
  logic [31:0] divisor_r;
  logic        signed_r;
  logic        op1_neg_r;
  logic        op2_neg_r;
  logic [63:0] result_r;
  logic        ready_r;

  logic [32:0] diff_s;
  logic [31:0] op1_abs_s;
  logic [31:0] op2_abs_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Trial subtract, operand magnitudes and sign fixup of the finished result.
  always_comb begin
    diff_s    = {1'b0, dividend_r[63:32]} - {1'b0, divisor_r};
    op1_abs_s = abs32(bus.opdata1_i, bus.signed_div_i);
    op2_abs_s = abs32(bus.opdata2_i, bus.signed_div_i);
    if (signed_r && (op1_neg_r ^ op2_neg_r)) begin
      quot_s = neg32(dividend_r[31:0]);
    end else begin
      quot_s = dividend_r[31:0];
    end
    // Remainder takes the sign of the dividend.
    if (signed_r && op1_neg_r) begin
      rem_s = neg32(dividend_r[64:33]);
    end else begin
      rem_s = dividend_r[64:33];
    end
  end

  // Divider control FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= DivFree;
      cnt_r      <= 6'd0;
      dividend_r <= 65'd0;
      divisor_r  <= 32'd0;
      signed_r   <= 1'b0;
      op1_neg_r  <= 1'b0;
      op2_neg_r  <= 1'b0;
      result_r   <= 64'd0;
      ready_r    <= DivResultNotReady;
    end else begin
      case (state_r)
        DivFree: begin
          result_r <= 64'd0;
          ready_r  <= DivResultNotReady;
          if ((bus.start_i == DivStart) && !bus.annul_i) begin
            signed_r   <= bus.signed_div_i;
            op1_neg_r  <= bus.signed_div_i & bus.opdata1_i[31];
            op2_neg_r  <= bus.signed_div_i & bus.opdata2_i[31];
            divisor_r  <= op2_abs_s;
            dividend_r <= {32'd0, op1_abs_s, 1'b0};
            cnt_r      <= 6'd0;
            if (bus.opdata2_i == 32'd0) begin
              state_r <= DivByZero;
            end else begin
              state_r <= DivOn;
            end
          end else begin
            state_r <= DivFree;
          end
        end
        DivByZero: begin
          result_r <= 64'd0;
          ready_r  <= DivResultReady;
          state_r  <= DivEnd;
        end
        DivOn: begin
          if (bus.annul_i) begin
            state_r <= DivFree;
            ready_r <= DivResultNotReady;
          end else if (cnt_r != DivIterCnt) begin
            if (diff_s[32]) begin
              dividend_r <= {dividend_r[63:0], 1'b0};
            end else begin
              dividend_r <= {diff_s[31:0], dividend_r[31:0], 1'b1};
            end
            cnt_r <= cnt_r + 6'd1;
          end else begin
            result_r <= {rem_s, quot_s};
            ready_r  <= DivResultReady;
            state_r  <= DivEnd;
            cnt_r    <= 6'd0;
          end
        end
        DivEnd: begin
          if ((bus.start_i == DivStop) || bus.annul_i) begin
            state_r  <= DivFree;
            result_r <= 64'd0;
            ready_r  <= DivResultNotReady;
          end else begin
            state_r <= DivEnd;
          end
        end
        default: begin
          state_r  <= DivFree;
          result_r <= 64'd0;
          ready_r  <= DivResultNotReady;
        end
      endcase
    end
  end

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;

endmodule
